// File: rtl/anton_neopixel_encoder_pkg.sv
// Shared types, defaults and RGB332 expansion for the NeoPixel encoder.
package anton_neopixel_encoder_pkg;

  localparam int unsigned BUFFER_END_DEFAULT = 255;
  localparam int unsigned T0H_TICKS_DEFAULT  = 2;
  localparam int unsigned T1H_TICKS_DEFAULT  = 5;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_FULL = 2'd2
  } fetch_state_e;

  typedef enum logic {
    STATE_TRANSMIT = 1'b0,
    STATE_RESET    = 1'b1
  } stream_state_e;

  // Expands one channel of a {R[2:0],G[2:0],B[1:0]} byte to 8 bits by bit replication.
  function automatic logic [7:0] rgb332_expand(input logic [7:0] px, input logic [1:0] ch);
    case (ch)
      2'd0:    return {px[7:5], px[7:5], px[7:6]};
      2'd1:    return {px[4:2], px[4:2], px[4:3]};
      2'd2:    return {4{px[1:0]}};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/anton_neopixel_byte_select.sv
// Picks the channel byte to transmit from a buffer word, for 8-bit or 32-bit mode.
module anton_neopixel_byte_select
  import anton_neopixel_encoder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_sel_i,
  input  logic [1:0]  channel_i,
  input  logic        mode32_i,
  output logic [7:0]  byte_o
);

  logic [7:0] px;

  always_comb begin
    case (byte_sel_i)
      2'd0:    px = word_i[7:0];
      2'd1:    px = word_i[15:8];
      2'd2:    px = word_i[23:16];
      default: px = word_i[31:24];
    endcase

    byte_o = '0;
    if (mode32_i) begin
      case (channel_i)
        2'd0:    byte_o = word_i[7:0];
        2'd1:    byte_o = word_i[15:8];
        2'd2:    byte_o = word_i[23:16];
        default: byte_o = '0;
      endcase
    end else begin
      byte_o = rgb332_expand(px, channel_i);
    end
  end

endmodule

// File: rtl/anton_neopixel_encoder.sv
// Prefetches pixel words one pixel ahead and encodes the current pixel onto the
// NeoPixel serial line; raises a sticky underrun flag when a word is late.
module anton_neopixel_encoder
  import anton_neopixel_encoder_pkg::*;
#(
  parameter  int unsigned BUFFER_END   = BUFFER_END_DEFAULT,
  parameter  int unsigned READ_LATENCY = 1,
  parameter  int unsigned T0H_TICKS    = T0H_TICKS_DEFAULT,
  parameter  int unsigned T1H_TICKS    = T1H_TICKS_DEFAULT,
  localparam int unsigned BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   rstn,
  input  logic                   regCtrlInit,
  input  logic                   regCtrlRun,
  input  logic                   regCtrl32bit,
  input  logic [2:0]             bitPatternIndex,
  input  logic [2:0]             pixelBitIndex,
  input  logic [1:0]             channelIndex,
  input  logic [BUFFER_BITS-1:0] pixelIndex,
  input  logic [BUFFER_BITS-1:0] pixelIndexMax,
  input  logic                   state,
  input  logic                   streamOutput,
  input  logic                   streamChannelOf,
  input  logic                   streamPixelOf,
  output logic                   ramRd,
  output logic [BUFFER_BITS-3:0] ramAddr,
  input  logic [31:0]            ramData,
  output logic                   neoData,
  output logic                   underrun
);

  localparam int unsigned WB  = BUFFER_BITS - 2;
  localparam logic [2:0]  LAT = 3'(READ_LATENCY);
  localparam logic [3:0]  T0H = 4'(T0H_TICKS);
  localparam logic [3:0]  T1H = 4'(T1H_TICKS);

  fetch_state_e  fetch_q, fetch_d;
  logic          req_q, req_d;
  logic [WB-1:0] addr_q, addr_d;
  logic          ramRd_q, ramRd_d;
  logic [2:0]    lat_q, lat_d;
  logic [31:0]   nextWord_q, nextWord_d;
  logic [31:0]   curWord_q, curWord_d;
  logic          loaded_q, loaded_d;
  logic          underrun_q, underrun_d;
  logic          neo_q, neo_d;

  logic          firstTick, atEnd, firstSwap, swap, curBit;
  logic [WB-1:0] nextAddr;
  logic [31:0]   swapWord, curWordEff;
  logic [7:0]    chanByte;

  always_comb begin
    firstTick = streamOutput && (channelIndex == 2'd0) && (pixelBitIndex == 3'd0)
                && (bitPatternIndex == 3'd0);
    atEnd = regCtrl32bit ? (pixelIndex[BUFFER_BITS-1:2] >= pixelIndexMax[BUFFER_BITS-1:2])
                         : (pixelIndex >= pixelIndexMax);
    // Word address of pixelIndex+1: in 8-bit mode the word only advances when leaving byte 3.
    nextAddr = '0;
    if (!atEnd)
      nextAddr = pixelIndex[BUFFER_BITS-1:2] + WB'(regCtrl32bit || (&pixelIndex[1:0]));

    // A pixel not yet loaded at the first transmit tick is swapped in and used on that same tick.
    firstSwap  = (state == STATE_TRANSMIT) && streamOutput && !loaded_q;
    swap       = firstSwap || streamChannelOf || streamPixelOf;
    swapWord   = (fetch_q == FETCH_FULL) ? nextWord_q : '0;
    curWordEff = firstSwap ? swapWord : curWord_q;
  end

  anton_neopixel_byte_select u_byte_select (
    .word_i     (curWordEff),
    .byte_sel_i (pixelIndex[1:0]),
    .channel_i  (channelIndex),
    .mode32_i   (regCtrl32bit),
    .byte_o     (chanByte)
  );

  assign curBit = chanByte[~pixelBitIndex];

  always_comb begin
    neo_d = regCtrlRun && !regCtrlInit && (state == STATE_TRANSMIT) && streamOutput
            && ({1'b0, bitPatternIndex} < (curBit ? T1H : T0H));
  end

  always_comb begin
    fetch_d    = fetch_q;
    req_d      = req_q;
    addr_d     = addr_q;
    ramRd_d    = 1'b0;
    lat_d      = lat_q;
    nextWord_d = nextWord_q;
    curWord_d  = curWord_q;
    loaded_d   = loaded_q;
    underrun_d = underrun_q;

    if (regCtrlInit) begin
      fetch_d    = FETCH_IDLE;
      req_d      = 1'b1;
      addr_d     = '0;
      lat_d      = '0;
      nextWord_d = '0;
      curWord_d  = '0;
      loaded_d   = 1'b0;
      underrun_d = 1'b0;
    end else begin
      case (fetch_q)
        FETCH_IDLE: if (req_q) begin
          ramRd_d = 1'b1;
          req_d   = 1'b0;
          lat_d   = '0;
          fetch_d = FETCH_WAIT;
        end
        FETCH_WAIT: if (lat_q == LAT) begin
          nextWord_d = ramData;
          fetch_d    = FETCH_FULL;
        end else begin
          lat_d = lat_q + 3'd1;
        end
        default: ;
      endcase

      // Swap is resolved before a same-cycle arm, so the new request issues next cycle.
      if (swap) begin
        curWord_d = swapWord;
        loaded_d  = 1'b1;
        if (fetch_q == FETCH_FULL) fetch_d = FETCH_IDLE;
        else                       underrun_d = 1'b1;
      end

      if (firstTick) begin
        req_d  = 1'b1;
        addr_d = nextAddr;
      end
    end
  end

  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn) begin
      fetch_q    <= FETCH_IDLE;
      req_q      <= 1'b1;
      addr_q     <= '0;
      ramRd_q    <= 1'b0;
      lat_q      <= '0;
      nextWord_q <= '0;
      curWord_q  <= '0;
      loaded_q   <= 1'b0;
      underrun_q <= 1'b0;
      neo_q      <= 1'b0;
    end else begin
      fetch_q    <= fetch_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      ramRd_q    <= ramRd_d;
      lat_q      <= lat_d;
      nextWord_q <= nextWord_d;
      curWord_q  <= curWord_d;
      loaded_q   <= loaded_d;
      underrun_q <= underrun_d;
      neo_q      <= neo_d;
    end
  end

  assign ramRd    = ramRd_q;
  assign ramAddr  = addr_q;
  assign neoData  = neo_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_anton_neopixel_encoder.sv
// Directed bench: drives stream positions by hand against a latency-4 RAM model.
module tb_anton_neopixel_encoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        regCtrlInit, regCtrlRun, regCtrl32bit;
  logic [2:0]  bitPatternIndex, pixelBitIndex;
  logic [1:0]  channelIndex;
  logic [3:0]  pixelIndex, pixelIndexMax;
  logic        state, streamOutput, streamChannelOf, streamPixelOf;
  logic        ramRd;
  logic [1:0]  ramAddr;
  logic [31:0] ramData;
  logic        neoData, underrun;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned base;

  always #5 clk = ~clk;

  anton_neopixel_encoder #(
    .BUFFER_END   (15),
    .READ_LATENCY (4),
    .T0H_TICKS    (2),
    .T1H_TICKS    (5)
  ) dut (
    .clk6_4mhz       (clk),
    .rstn            (rstn),
    .regCtrlInit     (regCtrlInit),
    .regCtrlRun      (regCtrlRun),
    .regCtrl32bit    (regCtrl32bit),
    .bitPatternIndex (bitPatternIndex),
    .pixelBitIndex   (pixelBitIndex),
    .channelIndex    (channelIndex),
    .pixelIndex      (pixelIndex),
    .pixelIndexMax   (pixelIndexMax),
    .state           (state),
    .streamOutput    (streamOutput),
    .streamChannelOf (streamChannelOf),
    .streamPixelOf   (streamPixelOf),
    .ramRd           (ramRd),
    .ramAddr         (ramAddr),
    .ramData         (ramData),
    .neoData         (neoData),
    .underrun        (underrun)
  );

  // RAM: data for a read sampled at edge k is on ramData after edge k+3 (latency 4).
  logic [31:0] ram  [0:3];
  logic [31:0] pipe [0:3];
  always @(posedge clk) begin
    pipe[0] <= ramRd ? ram[ramAddr] : 32'hDEAD_BEEF;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign ramData = pipe[3];

  int unsigned rd_count = 0;
  logic [1:0]  rd_log [0:63];
  always @(posedge clk) begin
    if (ramRd) begin
      rd_log[rd_count[5:0]] <= ramAddr;
      rd_count <= rd_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input string tag, input int unsigned n);
    state = 1'b1; streamOutput = 1'b0; streamChannelOf = 1'b0; streamPixelOf = 1'b0;
    channelIndex = '0; pixelBitIndex = '0; bitPatternIndex = '0; pixelIndex = '0;
    repeat (n) begin
      @(posedge clk); #1;
      check(tag, 32'(neoData), 32'd0);
    end
  endtask

  // exp holds the three transmitted channel bytes, first-sent byte in [23:16].
  task automatic send_pixel(input string tag, input logic [3:0] pix, input logic last,
                            input logic [23:0] exp, input int unsigned nticks);
    int unsigned n = 0;
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 8; b++)
        for (int p = 0; p < 8; p++) begin
          if (n < nticks) begin
            logic bv, eo;
            state = 1'b0; streamOutput = 1'b1; pixelIndex = pix;
            channelIndex = c[1:0]; pixelBitIndex = b[2:0]; bitPatternIndex = p[2:0];
            streamChannelOf = (c == 2 && b == 7 && p == 7);
            streamPixelOf   = streamChannelOf && last;
            bv = exp[23 - (c*8 + b)];
            eo = (p < (bv ? 5 : 2));
            @(posedge clk); #1;
            check(tag, 32'(neoData), 32'(eo));
            n++;
          end
        end
    streamOutput = 1'b0; streamChannelOf = 1'b0; streamPixelOf = 1'b0;
  endtask

  task automatic do_init();
    regCtrlInit = 1'b1;
    idle("init_neo", 2);
    regCtrlInit = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; regCtrlInit = 1'b0; regCtrlRun = 1'b1; regCtrl32bit = 1'b0;
    state = 1'b1; streamOutput = 1'b0; streamChannelOf = 1'b0; streamPixelOf = 1'b0;
    channelIndex = '0; pixelBitIndex = '0; bitPatternIndex = '0;
    pixelIndex = '0; pixelIndexMax = 4'd2;
    ram[0] = 32'h5503_1CE0; ram[1] = 32'h1234_5678; ram[2] = '0; ram[3] = '0;

    // Reset values
    repeat (2) @(posedge clk); #1;
    check("rst_neo",      32'(neoData),  32'd0);
    check("rst_ramRd",    32'(ramRd),    32'd0);
    check("rst_ramAddr",  32'(ramAddr),  32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    // 8-bit, max=2: bytes E0,1C,03 of word 0, then wrap to pixel 0
    rstn = 1'b1;
    base = rd_count;
    idle("A_pre", 10);
    check("A_rd_count0", rd_count - base, 32'd1);
    check("A_rd_addr0", 32'(rd_log[base[5:0]]), 32'd0);
    send_pixel("A_px0", 4'd0, 1'b0, 24'hFF_00_00, 192);
    send_pixel("A_px1", 4'd1, 1'b0, 24'h00_FF_00, 192);
    send_pixel("A_px2", 4'd2, 1'b1, 24'h00_00_FF, 192);
    idle("A_gap", 6);
    send_pixel("A_wrap_px0", 4'd0, 1'b0, 24'hFF_00_00, 192);
    idle("A_post", 4);
    check("A_rd_count", rd_count - base, 32'd5);
    for (int k = 1; k < 5; k++)
      check("A_rd_addr", 32'(rd_log[6'(base + k)]), 32'd0);
    check("A_underrun", 32'(underrun), 32'd0);

    // 32-bit, word0=00A5FF01 word1=12345678, pixels at byte 0 and 4
    ram[0] = 32'h00A5_FF01;
    regCtrl32bit = 1'b1; pixelIndexMax = 4'd4;
    do_init();
    base = rd_count;
    idle("B_pre", 10);
    check("B_rd_count0", rd_count - base, 32'd1);
    check("B_rd_addr0", 32'(rd_log[base[5:0]]), 32'd0);
    send_pixel("B_px0", 4'd0, 1'b0, 24'h01_FF_A5, 192);
    send_pixel("B_px1", 4'd4, 1'b1, 24'h78_56_34, 192);
    idle("B_post", 6);
    check("B_rd_count", rd_count - base, 32'd3);
    check("B_rd_addr1", 32'(rd_log[6'(base + 1)]), 32'd1);
    check("B_rd_addr2", 32'(rd_log[6'(base + 2)]), 32'd0);
    check("B_underrun", 32'(underrun), 32'd0);

    // Init during transmit: prefetched word 1 must be discarded
    send_pixel("E_partial", 4'd0, 1'b0, 24'h01_FF_A5, 40);
    do_init();
    base = rd_count;
    idle("E_pre", 10);
    check("E_rd_count0", rd_count - base, 32'd1);
    check("E_rd_addr0", 32'(rd_log[base[5:0]]), 32'd0);
    send_pixel("E_px0", 4'd0, 1'b0, 24'h01_FF_A5, 192);
    send_pixel("E_px1", 4'd4, 1'b1, 24'h78_56_34, 192);
    idle("E_post", 4);
    check("E_underrun", 32'(underrun), 32'd0);

    // rstn mid-bit while the word-1 read is in flight
    ram[0] = 32'h00A5_FF81;
    do_init();
    base = rd_count;
    idle("D_pre", 10);
    check("D_rd_count0", rd_count - base, 32'd1);
    send_pixel("D_partial", 4'd0, 1'b0, 24'h81_FF_A5, 4);
    check("D_inflight_count", rd_count - base, 32'd2);
    check("D_inflight_addr", 32'(rd_log[6'(base + 1)]), 32'd1);
    rstn = 1'b0;
    #1;
    check("D_rst_neo",   32'(neoData), 32'd0);
    check("D_rst_ramRd", 32'(ramRd),   32'd0);
    idle("D_in_reset", 3);
    rstn = 1'b1;
    base = rd_count;
    idle("D_release", 10);
    check("D_rd_count", rd_count - base, 32'd1);
    check("D_rd_addr0", 32'(rd_log[base[5:0]]), 32'd0);
    send_pixel("D_px0", 4'd0, 1'b0, 24'h81_FF_A5, 192);
    send_pixel("D_px1", 4'd4, 1'b1, 24'h78_56_34, 192);
    idle("D_post", 4);
    check("D_underrun", 32'(underrun), 32'd0);

    // Underrun: first pixel starts before the fetch completes
    ram[0] = 32'h5503_1CE0;
    regCtrl32bit = 1'b0; pixelIndexMax = 4'd2;
    do_init();
    send_pixel("C_px0_zero", 4'd0, 1'b0, 24'h00_00_00, 192);
    check("C_underrun_set", 32'(underrun), 32'd1);
    idle("C_hold", 20);
    check("C_underrun_sticky", 32'(underrun), 32'd1);
    regCtrlInit = 1'b1;
    @(posedge clk); #1;
    check("C_underrun_clear", 32'(underrun), 32'd0);
    regCtrlInit = 1'b0;
    idle("C_post", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
